// File: rtl/skid_pkg.sv
// Shared constants for the two-entry skid output stage.
// State encoding and stall counter width.
package skid_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int STALL_W = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and enable.
// Holds at all-ones once reached.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/reg_skid_buffer.sv
// Two-entry valid/ready output stage with state-decoded handshakes.
// Optional stall counter port under SKID_STALL_CNT_EN.
module reg_skid_buffer
  import skid_pkg::*;
#(
  parameter int          N = 8,
  parameter logic [N-1:0] V = '0
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               in_valid,
  input  logic [N-1:0]       in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [N-1:0]       out_data,
`ifdef SKID_STALL_CNT_EN
  output logic [STALL_W-1:0] stall_cnt,
`endif
  input  logic               out_ready
);

  logic [1:0]   r_st;
  logic [N-1:0] r_m;
  logic [N-1:0] r_s;

  logic w_in_xfer;
  logic w_out_xfer;

  assign in_ready  = (r_st == ST_EMPTY) || (r_st == ST_ONE);
  assign out_valid = (r_st == ST_ONE) || (r_st == ST_FULL);
  assign out_data  = r_m;

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_st <= ST_EMPTY;
      r_m  <= V;
      r_s  <= V;
    end else begin
      case (r_st)
        ST_EMPTY: begin
          if (in_valid) begin
            r_m  <= in_data;
            r_st <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_m <= in_data;
          end else if (w_in_xfer) begin
            r_s  <= in_data;
            r_st <= ST_FULL;
          end else if (w_out_xfer) begin
            r_st <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            r_m  <= r_s;
            r_st <= ST_ONE;
          end
        end
        // encoding 3 is unreachable; fall back to empty
        default: r_st <= ST_EMPTY;
      endcase
    end
  end

`ifdef SKID_STALL_CNT_EN
  logic w_stall;

  assign w_stall = out_valid && !out_ready;

  sat_counter #(
    .W(STALL_W)
  ) u_stall_cnt (
    .clk   (clk),
    .i_clr (clr),
    .i_en  (w_stall),
    .o_cnt (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_reg_skid_buffer.sv
// Directed bench for reg_skid_buffer (N=8, V=8'h5A).
// Stall counter checks run only with SKID_STALL_CNT_EN.
module tb_reg_skid_buffer;

  logic       clk;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
`ifdef SKID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks;
  int errors;

  reg_skid_buffer #(
    .N(8),
    .V(8'h5A)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
`ifdef SKID_STALL_CNT_EN
    .stall_cnt (stall_cnt),
`endif
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_st(input string tag,
                        input logic ir,
                        input logic ov,
                        input logic [7:0] od);
    check({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, ir});
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    check({tag, ".out_data"}, {24'd0, out_data}, {24'd0, od});
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    clr       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    tick();
    tick();
    clr = 1'b0;
    chk_st("reset", 1'b1, 1'b0, 8'h5A);
    tick();
    chk_st("idle", 1'b1, 1'b0, 8'h5A);

    // streaming 01..10 with consumer always ready
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
      chk_st($sformatf("stream%0d", i), 1'b1, 1'b1, 8'(i));
    end
    in_valid = 1'b0;
    tick();
    chk_st("drain", 1'b1, 1'b0, 8'h10);

    // backpressure
    in_valid = 1'b1;
    in_data  = 8'hA1;
    tick();
    chk_st("bp_a1", 1'b1, 1'b1, 8'hA1);
    out_ready = 1'b0;
    in_data   = 8'hA2;
    tick();
    chk_st("bp_full", 1'b0, 1'b1, 8'hA1);
    in_data = 8'hA3;
    tick();
    chk_st("bp_hold", 1'b0, 1'b1, 8'hA1);
    tick();
    chk_st("bp_hold2", 1'b0, 1'b1, 8'hA1);
    out_ready = 1'b1;
    tick();
    chk_st("bp_a2", 1'b1, 1'b1, 8'hA2);
    tick();
    chk_st("bp_a3", 1'b1, 1'b1, 8'hA3);
    in_valid = 1'b0;
    tick();
    chk_st("bp_empty", 1'b1, 1'b0, 8'hA3);

    // mid-operation reset from FULL
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA1;
    tick();
    in_data = 8'hA2;
    tick();
    chk_st("mr_full", 1'b0, 1'b1, 8'hA1);
    clr       = 1'b1;
    out_ready = 1'b1;
    in_data   = 8'hC3;
    tick();
    clr      = 1'b0;
    in_valid = 1'b0;
    chk_st("mr_clr", 1'b1, 1'b0, 8'h5A);
    tick();
    chk_st("mr_after", 1'b1, 1'b0, 8'h5A);

    // simultaneous in/out in ONE
    in_valid = 1'b1;
    in_data  = 8'h33;
    tick();
    chk_st("sim_33", 1'b1, 1'b1, 8'h33);
    in_data = 8'h44;
    tick();
    chk_st("sim_44", 1'b1, 1'b1, 8'h44);
    in_valid = 1'b0;
    tick();
    chk_st("sim_empty", 1'b1, 1'b0, 8'h44);

`ifdef SKID_STALL_CNT_EN
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("stall_clr", {16'd0, stall_cnt}, 32'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hB5;
    tick();
    in_valid = 1'b0;
    check("stall_0", {16'd0, stall_cnt}, 32'd0);
    repeat (10) tick();
    check("stall_10", {16'd0, stall_cnt}, 32'd10);
    repeat (69990) tick();
    check("stall_sat", {16'd0, stall_cnt}, 32'hFFFF);
    chk_st("stall_hold", 1'b1, 1'b1, 8'hB5);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("stall_rst", {16'd0, stall_cnt}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
